// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
// Optional feature macro used by the arbiter: UART_ARB_LOCK_EN.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } arb_state_t;

  localparam int DEF_TIMEOUT_CLKS = 4096;
  localparam int DEF_GAP_CLKS     = 0;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin search: first set request at or above the
// pointer, wrapping modulo N_REQ.
module uart_rr_picker
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int GW    = grant_w(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [GW-1:0]    i_ptr,
  output logic [GW-1:0]    o_winner,
  output logic             o_valid
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest hit is written last.
  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = 0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      w_idx = (int'(i_ptr) + off) % N_REQ;
      if (i_req[w_idx]) begin
        o_winner = GW'(w_idx);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among N_REQ byte requesters,
// with done watchdog and post-frame idle gap. Optional lock: UART_ARB_LOCK_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter  int N_REQ        = 4,
  parameter  int GAP_CLKS     = DEF_GAP_CLKS,
  parameter  int TIMEOUT_CLKS = DEF_TIMEOUT_CLKS,
  localparam int GW           = grant_w(N_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [8*N_REQ-1:0] i_byte,
`ifdef UART_ARB_LOCK_EN
  input  logic [N_REQ-1:0]   i_lock,
`endif
  output logic [N_REQ-1:0]   o_ack,
  output logic [N_REQ-1:0]   o_done,
  output logic               o_err,
  output logic               o_busy,
  output logic [GW-1:0]      o_grant_id,
  output logic               o_tx_dv,
  output logic [7:0]         o_tx_byte,
  input  logic               i_tx_active,
  input  logic               i_tx_done
);

  localparam int WD_W  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int GAP_W = (GAP_CLKS > 2) ? $clog2(GAP_CLKS) : 1;
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CLKS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  arb_state_t        r_state, w_state_nxt;
  logic [GW-1:0]     r_ptr, r_grant_id;
  logic [WD_W-1:0]   r_wd;
  logic [GAP_W-1:0]  r_gap;
  logic [N_REQ-1:0]  r_ack, r_done;
  logic              r_err, r_tx_dv;
  logic [7:0]        r_tx_byte;

  logic [GW-1:0]     w_pick_id, w_sel, w_ptr_nxt;
  logic              w_pick_valid, w_sel_valid;
  logic              w_launch, w_done_ev, w_err_ev;
  logic [7:0]        w_sel_byte;
  logic [N_REQ-1:0]  w_ack_nxt, w_done_nxt;

`ifdef UART_ARB_LOCK_EN
  logic              r_lock_hold;
  logic              w_lock_keep;
`endif

  uart_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_winner (w_pick_id),
    .o_valid  (w_pick_valid)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_done_ev   = 1'b0;
    w_err_ev    = 1'b0;
    w_sel       = w_pick_id;
    w_sel_valid = w_pick_valid;
`ifdef UART_ARB_LOCK_EN
    // A locked last grantee that still requests overrides the pointer.
    w_lock_keep = r_lock_hold && i_lock[r_grant_id] && i_req[r_grant_id];
    if (w_lock_keep) begin
      w_sel       = r_grant_id;
      w_sel_valid = 1'b1;
    end
`endif
    case (r_state)
      IDLE: begin
        if (w_sel_valid && !i_tx_active) begin
          w_launch    = 1'b1;
          w_state_nxt = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_tx_done) begin
          w_done_ev   = 1'b1;
          w_state_nxt = (GAP_CLKS == 0) ? IDLE : GAP;
        end else if (r_wd == WD_MAX) begin
          w_err_ev    = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      GAP: begin
        if (r_gap == GAP_LAST) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_sel_byte = 8'h00;
    w_ack_nxt  = '0;
    w_done_nxt = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_sel == GW'(k)) w_sel_byte = i_byte[k*8 +: 8];
      w_ack_nxt[k]  = w_launch && (w_sel == GW'(k));
      w_done_nxt[k] = w_done_ev && (r_grant_id == GW'(k));
    end
    w_ptr_nxt = (w_sel == GW'(N_REQ - 1)) ? '0 : w_sel + 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_wd       <= '0;
      r_gap      <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_err      <= 1'b0;
      r_tx_dv    <= 1'b0;
      r_tx_byte  <= 8'h00;
`ifdef UART_ARB_LOCK_EN
      r_lock_hold <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_ev;
      r_tx_dv <= w_launch;
      if (w_launch) begin
        r_tx_byte  <= w_sel_byte;
        r_grant_id <= w_sel;
        r_ptr      <= w_ptr_nxt;
      end
      if (r_state == WAIT_DONE && w_state_nxt == WAIT_DONE) r_wd <= r_wd + 1'b1;
      else                                                   r_wd <= '0;
      if (r_state == GAP && w_state_nxt == GAP) r_gap <= r_gap + 1'b1;
      else                                       r_gap <= '0;
`ifdef UART_ARB_LOCK_EN
      if (w_err_ev)      r_lock_hold <= 1'b0;
      else if (w_launch) r_lock_hold <= 1'b1;
`endif
    end
  end

  assign o_ack      = r_ack;
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_busy     = (r_state != IDLE);
  assign o_grant_id = r_grant_id;
  assign o_tx_dv    = r_tx_dv;
  assign o_tx_byte  = r_tx_byte;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: dut a (GAP_CLKS=0, TIMEOUT_CLKS=64)
// and dut b (GAP_CLKS=5); lock scenario only when UART_ARB_LOCK_EN is defined.
module tb_uart_tx_arbiter;

  // Handshake: a requester holds i_req with a stable byte until its one-cycle
  // o_ack; the arbiter launches with a one-cycle o_tx_dv and expects i_tx_done.

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tx_active;

  logic [3:0]  a_req, a_ack, a_done, a_lock;
  logic [31:0] a_byte;
  logic        a_err, a_busy, a_tx_dv, a_tx_done;
  logic [1:0]  a_grant;
  logic [7:0]  a_tx_byte;

  logic [3:0]  b_req, b_ack, b_done, b_lock;
  logic [31:0] b_byte;
  logic        b_err, b_busy, b_tx_dv, b_tx_done;
  logic [1:0]  b_grant;
  logic [7:0]  b_tx_byte;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1, "global timeout");
  end

  uart_tx_arbiter #(.N_REQ(4), .GAP_CLKS(0), .TIMEOUT_CLKS(64)) u_dut_a (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (a_req),
    .i_byte      (a_byte),
`ifdef UART_ARB_LOCK_EN
    .i_lock      (a_lock),
`endif
    .o_ack       (a_ack),
    .o_done      (a_done),
    .o_err       (a_err),
    .o_busy      (a_busy),
    .o_grant_id  (a_grant),
    .o_tx_dv     (a_tx_dv),
    .o_tx_byte   (a_tx_byte),
    .i_tx_active (tx_active),
    .i_tx_done   (a_tx_done)
  );

  uart_tx_arbiter #(.N_REQ(4), .GAP_CLKS(5), .TIMEOUT_CLKS(4096)) u_dut_b (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_req       (b_req),
    .i_byte      (b_byte),
`ifdef UART_ARB_LOCK_EN
    .i_lock      (b_lock),
`endif
    .o_ack       (b_ack),
    .o_done      (b_done),
    .o_err       (b_err),
    .o_busy      (b_busy),
    .o_grant_id  (b_grant),
    .o_tx_dv     (b_tx_dv),
    .o_tx_byte   (b_tx_byte),
    .i_tx_active (tx_active),
    .i_tx_done   (b_tx_done)
  );

  function automatic logic [31:0] onehot(input int id);
    return 32'(1) << id;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for o_tx_dv of the selected dut; n = budget+1 on expiry.
  task automatic wait_dv(input bit sel, input int budget, output int n);
    n = 0;
    while (n <= budget) begin
      @(negedge clk);
      n++;
      if (sel ? b_tx_dv : a_tx_dv) break;
    end
  endtask

  task automatic a_launch(input string tag, input int id, input logic [7:0] byt);
    int n;
    wait_dv(1'b0, 8, n);
    check({tag, "_lat"},   32'(n), 32'd1);
    check({tag, "_ack"},   32'(a_ack), onehot(id));
    check({tag, "_grant"}, 32'(a_grant), 32'(id));
    check({tag, "_byte"},  32'(a_tx_byte), 32'(byt));
    check({tag, "_busy"},  32'(a_busy), 32'd1);
  endtask

  task automatic a_finish(input string tag, input int id);
    @(negedge clk);
    a_tx_done = 1'b1;
    @(negedge clk);
    a_tx_done = 1'b0;
    check({tag, "_done"}, 32'(a_done), onehot(id));
    check({tag, "_err"},  32'(a_err), 32'd0);
  endtask

  initial begin
    int n;
    bit saw_done;
    logic [31:0] exp_id;

    rst_n = 1'b0; tx_active = 1'b0;
    a_req = '0; a_byte = '0; a_lock = '0; a_tx_done = 1'b0;
    b_req = '0; b_byte = '0; b_lock = '0; b_tx_done = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ack",   32'(a_ack), 32'd0);
    check("rst_done",  32'(a_done), 32'd0);
    check("rst_err",   32'(a_err), 32'd0);
    check("rst_busy",  32'(a_busy), 32'd0);
    check("rst_dv",    32'(a_tx_dv), 32'd0);
    check("rst_byte",  32'(a_tx_byte), 32'd0);
    check("rst_grant", 32'(a_grant), 32'd0);
    rst_n = 1'b1;

    // Foreign frame in flight: request is held off
    @(negedge clk);
    tx_active = 1'b1;
    a_req = 4'b0001; a_byte[7:0] = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_dv", 32'(a_tx_dv), 32'd0);
    end
    tx_active = 1'b0;

    // Single request
    a_launch("single", 0, 8'hA5);
    a_req = '0; a_byte[7:0] = 8'h00;
    @(negedge clk);
    check("single_dv_low",  32'(a_tx_dv), 32'd0);
    check("single_ack_low", 32'(a_ack), 32'd0);
    a_finish("single", 0);
    check("single_idle", 32'(a_busy), 32'd0);

    // Stray tx_done in IDLE is ignored
    a_tx_done = 1'b1;
    @(negedge clk);
    a_tx_done = 1'b0;
    @(negedge clk);
    check("stray_done", 32'(a_done), 32'd0);

    // Watchdog: 64 WAIT_DONE cycles without tx_done
    a_req = 4'b0010; a_byte[15:8] = 8'h3C;
    a_launch("to", 1, 8'h3C);
    a_req = '0;
    n = 0; saw_done = 1'b0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (a_done != 4'b0000) saw_done = 1'b1;
      if (a_err) break;
    end
    check("to_cycles", 32'(n), 32'd64);
    check("to_nodone", 32'(saw_done), 32'd0);
    check("to_busy",   32'(a_busy), 32'd0);
    @(negedge clk);
    check("to_err_pulse", 32'(a_err), 32'd0);

    a_req = 4'b0100; a_byte[23:16] = 8'hC3;
    a_launch("after_to", 2, 8'hC3);
    a_req = '0;

    // Reset mid-frame
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_busy",  32'(a_busy), 32'd0);
    check("mid_rst_byte",  32'(a_tx_byte), 32'd0);
    check("mid_rst_grant", 32'(a_grant), 32'd0);
    check("mid_rst_ack",   32'(a_ack), 32'd0);
    rst_n = 1'b1;

    // Fairness, all four held: order 0,1,2,3,0,1,2,3 from a reset pointer
    a_req = 4'b1111; a_byte = 32'h13121110;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
    for (int f = 0; f < 8; f++) begin
      exp_id = exp_q.pop_front();
      a_launch("fair", int'(exp_id), 8'h10 + exp_id[7:0]);
      if (f == 7) a_req = '0;
      a_finish("fair", int'(exp_id));
    end

`ifdef UART_ARB_LOCK_EN
    // Move the pointer to 2, then requester 2 locks for three bytes
    a_req = 4'b0010;
    a_launch("lk_pre", 1, 8'h11);
    a_req = '0;
    a_finish("lk_pre", 1);
    a_req = 4'b0110; a_lock = 4'b0100;
    exp_q.push_back(32'd2); exp_q.push_back(32'd2);
    exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    for (int f = 0; f < 4; f++) begin
      exp_id = exp_q.pop_front();
      a_launch("lock", int'(exp_id), 8'h10 + exp_id[7:0]);
      if (f == 2) begin a_lock = '0; a_req = 4'b0010; end
      if (f == 3) a_req = '0;
      a_finish("lock", int'(exp_id));
    end
`endif

    // Gap of 5 clocks on dut b
    b_req = 4'b0011; b_byte = 32'h00002221;
    wait_dv(1'b1, 8, n);
    check("gap_first_lat", 32'(n), 32'd1);
    check("gap_first_ack", 32'(b_ack), 32'b0001);
    @(negedge clk);
    b_tx_done = 1'b1;
    @(negedge clk);
    b_tx_done = 1'b0;
    check("gap_done", 32'(b_done), 32'b0001);
    check("gap_busy", 32'(b_busy), 32'd1);
    wait_dv(1'b1, 20, n);
    check("gap_cycles",    32'(n), 32'd6);
    check("gap_second_ack", 32'(b_ack), 32'b0010);
    check("gap_second_byte", 32'(b_tx_byte), 32'h22);
    b_req = '0;

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
